fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
// - Instruction fetch stage, directly upstream of the decoder.
// - Owns the fetch PC and issues word requests to instruction memory with
//   multiple requests in flight.
// - Buffers returned instructions in a FIFO and presents {instr, pc} to decode
//   with a valid/ready handshake.
// - On a redirect (branch/jump/trap) it drops buffered and in-flight
//   instructions and restarts fetch at the new PC.
// PARAMETERS
// - XLEN       32  data/address width
// - DEPTH      4   FIFO entries; also the maximum number of outstanding requests (power of 2, >=2)
// - RESET_ADR  0   PC value after reset
// PORTS
// - clk           in   1     clock
// - reset_n       in   1     synchronous active-low reset
// - if_req_o      out  1     fetch request valid
// - if_adr_o      out  XLEN  fetch address (= PC)
// - if_gnt_i      in   1     memory accepted request this cycle
// - if_rvalid_i   in   1     response valid (in order, >=1 cycle after grant)
// - if_rdata_i    in   XLEN  response instruction word
// - redirect_v_i  in   1     flush + restart fetch
// - redirect_adr_i in  XLEN  new PC
// - instr_v_o     out  1     instruction valid to decoder
// - instr_o       out  XLEN  instruction word (feeds decoder instr_i)
// - pc_o          out  XLEN  PC of instr_o
// - dec_ready_i   in   1     decoder consumes when instr_v_o & dec_ready_i
// BEHAVIOUR
// - Reset (reset_n=0 at posedge): pc=RESET_ADR, fifo count=0, outstanding=0, drop=0.
//   Outputs: if_req_o=0, instr_v_o=0, instr_o=0, pc_o=0, if_adr_o=RESET_ADR.
//   Reset mid-transaction discards all state; responses for pre-reset grants
//   are not guaranteed to be tracked (the memory is reset together with this block).
// - if_req_o = ~redirect_v_i & (outstanding < DEPTH) & (count + outstanding - drop < DEPTH).
//   Combinational; no dependence on if_gnt_i.
// - Grant (if_req_o & if_gnt_i): pc <= pc + 4 (wraps modulo 2^XLEN); outstanding += 1.
// - if_adr_o is held stable while if_req_o=1 and no grant.
// - Response (if_rvalid_i): outstanding -= 1.
//   - If drop>0: drop -= 1, data discarded.
//   - Else: push {if_rdata_i, response PC} into the FIFO.
//   - Response PC comes from an internal PC FIFO of depth DEPTH, written at grant.
// - Pop when instr_v_o & dec_ready_i.
// - Simultaneous push and pop: count unchanged. A push into a full FIFO cannot
//   occur by construction; flag it with an assertion.
// - instr_v_o = (count != 0); instr_o/pc_o = FIFO head (registered storage).
// - Latency: grant at cycle N, rvalid at N+k (k>=1) -> instr_v_o at N+k+1.
// - Redirect (redirect_v_i=1): has priority over everything else in that cycle.
//   - pc <= redirect_adr_i; count <= 0; no grant (if_req_o forced 0).
//   - Pop is ignored.
//   - drop <= outstanding - if_rvalid_i, so every in-flight response is discarded.
//   - A response arriving in the redirect cycle itself is discarded.
//   - Back-to-back redirects: the last one wins; drop is recomputed each cycle.
// - redirect_adr_i[1:0] is used as-is; alignment is checked downstream.
// - Counters are $clog2(DEPTH)+1 bits wide; they never overflow.
// CONFIGURATION
// - FETCH_BYPASS_EN defined:
//   - When count==0, drop==0, no redirect and if_rvalid_i=1: instr_v_o=1 in the
//     same cycle with instr_o=if_rdata_i and pc_o=response PC.
//   - If dec_ready_i=1 in that cycle, the word is not written to the FIFO
//     (latency N+k).
//   - Otherwise it is pushed normally.
// - FETCH_BYPASS_EN undefined:
//   - All outputs come from FIFO registers; no combinational path from
//     if_rvalid_i/if_rdata_i to the outputs.
// TESTING
// - Reset: hold reset_n=0 2 cycles, release; gnt=1, rvalid 1 cycle later ->
//   if_adr_o sequence 0x0,0x4,0x8; pc_o follows 0x0,0x4,0x8; instr_o matches the memory model.
// - Backpressure: dec_ready_i=0, DEPTH=4, gnt always 1 ->
//   exactly 4 grants, then if_req_o=0; count=4; release -> order 0x0..0xC preserved, fetch resumes at 0x10.
// - Redirect with 3 in flight (rvalid latency 3):
//   redirect_adr_i=0x100 -> those 3 responses dropped; first pc_o after is 0x100; no stale instr_v_o.
// - Redirect on the same cycle as rvalid and a pending pop ->
//   response dropped, no pop counted, next if_adr_o=redirect target.
// - Stalled grant: if_gnt_i=0 for 5 cycles -> if_adr_o stable at 0x8, pc does not advance.
// - Wrap: RESET_ADR=0xFFFFFFFC -> second request address 0x00000000.
// - FETCH_BYPASS_EN: empty FIFO, dec_ready_i=1, rvalid with 0x00000013 ->
//   instr_v_o=1 and instr_o=0x00000013 in that cycle; count stays 0.

Source files
------------

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue -- instruction fetch stage sitting directly in front of decode.
//
// Owns the fetch PC and issues one word request per grant to instruction
// memory. Up to DEPTH requests can be in flight at once. Returned words are
// buffered in a DEPTH-entry FIFO and handed to decode as {instr, pc} over a
// valid/ready handshake. A redirect flushes the buffered words, discards every
// in-flight response and restarts fetch at the new PC.
//
// Optional feature macro: FETCH_BYPASS_EN
//   When defined, a response that arrives while the FIFO is empty (and nothing
//   is being dropped) is shown to decode in the same cycle. If decode takes it,
//   the word never enters the FIFO. When undefined, every output comes from
//   registers.
//
// Parameters:
//   XLEN       data/address width
//   DEPTH      FIFO entries and maximum outstanding requests (power of 2, >= 2)
//   RESET_ADR  PC after reset
//
// Ports:
//   clk             clock
//   reset_n         synchronous active-low reset
//   if_req_o        fetch request valid
//   if_adr_o        fetch address (the current PC)
//   if_gnt_i        memory accepted the request this cycle
//   if_rvalid_i     response valid (in order, at least 1 cycle after grant)
//   if_rdata_i      response instruction word
//   redirect_v_i    flush and restart fetch
//   redirect_adr_i  new PC
//   instr_v_o       instruction valid to decode
//   instr_o         instruction word
//   pc_o            PC of instr_o
//   dec_ready_i     decode consumes when instr_v_o & dec_ready_i
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int unsigned          XLEN      = 32,
  parameter int unsigned          DEPTH     = 4,
  parameter logic [XLEN-1:0]      RESET_ADR = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            if_req_o,
  output logic [XLEN-1:0] if_adr_o,
  input  logic            if_gnt_i,
  input  logic            if_rvalid_i,
  input  logic [XLEN-1:0] if_rdata_i,
  input  logic            redirect_v_i,
  input  logic [XLEN-1:0] redirect_adr_i,
  output logic            instr_v_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  input  logic            dec_ready_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_C1 = (CW + 1)'(DEPTH);

  // Architectural state
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;

  // Instruction FIFO pointers and the PC FIFO pointers (PC FIFO tracks the
  // address of every in-flight request so responses can be tagged).
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   pcw_ptr_q, pcw_ptr_d;
  logic [AW-1:0]   pcr_ptr_q, pcr_ptr_d;

  // Storage (no reset needed; occupancy is tracked by the counters)
  logic [XLEN-1:0] instr_mem_q [DEPTH];
  logic [XLEN-1:0] ipc_mem_q   [DEPTH];
  logic [XLEN-1:0] pcq_mem_q   [DEPTH];

  logic            grant;
  logic            fifo_v;
  logic            resp_keep;
  logic            push;
  logic            pop;
  logic            byp_take;
  logic [XLEN-1:0] resp_pc;
  logic [CW:0]     occupancy;

  // ---------------------------------------------------------------------------
  // Request side
  // ---------------------------------------------------------------------------
  // Slots already committed: buffered words plus in-flight responses that will
  // actually be kept (dropped ones never reach the FIFO).
  assign occupancy = {1'b0, count_q} + {1'b0, outst_q} - {1'b0, drop_q};

  assign if_req_o = reset_n & ~redirect_v_i & (outst_q < DEPTH_C) &
                    (occupancy < DEPTH_C1);
  assign if_adr_o = pc_q;
  assign grant    = if_req_o & if_gnt_i;

  // ---------------------------------------------------------------------------
  // Response side
  // ---------------------------------------------------------------------------
  assign resp_pc   = pcq_mem_q[pcr_ptr_q];
  assign resp_keep = if_rvalid_i & (drop_q == '0) & ~redirect_v_i;
  assign fifo_v    = (count_q != '0);
  assign pop       = fifo_v & dec_ready_i & ~redirect_v_i;
  assign push      = resp_keep & ~byp_take;

`ifdef FETCH_BYPASS_EN
  logic byp;
  // Empty FIFO and a keepable response: show it to decode immediately.
  assign byp       = reset_n & resp_keep & ~fifo_v;
  assign byp_take  = byp & dec_ready_i;
  assign instr_v_o = fifo_v | byp;
  assign instr_o   = fifo_v ? instr_mem_q[rd_ptr_q] : (byp ? if_rdata_i : '0);
  assign pc_o      = fifo_v ? ipc_mem_q[rd_ptr_q]   : (byp ? resp_pc    : '0);
`else
  assign byp_take  = 1'b0;
  assign instr_v_o = fifo_v;
  // Head is masked to zero when empty so the outputs read 0 after reset.
  assign instr_o   = fifo_v ? instr_mem_q[rd_ptr_q] : '0;
  assign pc_o      = fifo_v ? ipc_mem_q[rd_ptr_q]   : '0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d      = pc_q;
    count_d   = count_q;
    outst_d   = outst_q;
    drop_d    = drop_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    pcw_ptr_d = pcw_ptr_q;
    pcr_ptr_d = pcr_ptr_q;

    // The PC FIFO always advances on a response, kept or dropped, so it stays
    // aligned with the memory's in-order response stream.
    if (if_rvalid_i) begin
      pcr_ptr_d = pcr_ptr_q + AW'(1);
    end

    if (redirect_v_i) begin
      pc_d     = redirect_adr_i;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      // Everything still in flight after this cycle belongs to the old path.
      outst_d  = outst_q - CW'(if_rvalid_i);
      drop_d   = outst_q - CW'(if_rvalid_i);
    end else begin
      if (grant) begin
        pc_d      = pc_q + XLEN'(4);
        pcw_ptr_d = pcw_ptr_q + AW'(1);
      end
      outst_d = outst_q + CW'(grant) - CW'(if_rvalid_i);
      if (if_rvalid_i && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q      <= RESET_ADR;
      count_q   <= '0;
      outst_q   <= '0;
      drop_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pcw_ptr_q <= '0;
      pcr_ptr_q <= '0;
    end else begin
      pc_q      <= pc_d;
      count_q   <= count_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pcw_ptr_q <= pcw_ptr_d;
      pcr_ptr_q <= pcr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= if_rdata_i;
      ipc_mem_q[wr_ptr_q]   <= resp_pc;
    end
    if (grant) begin
      pcq_mem_q[pcw_ptr_q] <= pc_q;
    end
  end

  // Request throttling guarantees the FIFO never overflows.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(push && (count_q == DEPTH_C) && !pop));
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam logic [31:0] RST_ADR = 32'h0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req_o;
  logic [31:0] if_adr_o;
  logic        if_gnt_i;
  logic        if_rvalid_i;
  logic [31:0] if_rdata_i;
  logic        redirect_v_i;
  logic [31:0] redirect_adr_i;
  logic        instr_v_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        dec_ready_i;

  always #5 clk = ~clk;

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_ADR(RST_ADR)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .if_req_o       (if_req_o),
    .if_adr_o       (if_adr_o),
    .if_gnt_i       (if_gnt_i),
    .if_rvalid_i    (if_rvalid_i),
    .if_rdata_i     (if_rdata_i),
    .redirect_v_i   (redirect_v_i),
    .redirect_adr_i (redirect_adr_i),
    .instr_v_o      (instr_v_o),
    .instr_o        (instr_o),
    .pc_o           (pc_o),
    .dec_ready_i    (dec_ready_i)
  );

  // Instruction memory contents as a pure function of address (mem(0)=0x13).
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'h0000_0013;
  endfunction

  typedef struct {
    logic [31:0] adr;
    int          t;
  } pend_t;

  pend_t       pend[$];     // memory model: accepted requests awaiting response
  logic [31:0] exp_q[$];    // scoreboard: PCs decode should receive, in order
  logic [31:0] exp_fetch;   // next architectural fetch address
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          last_t = 0;
  int          lat_lo = 1;
  int          lat_hi = 1;
  int          grants = 0;

  logic        last_req, last_v, last_gnt;
  logic [31:0] last_adr, last_instr, last_grant_adr;

  task automatic check(input string name, input logic ok,
                       input logic [31:0] act, input logic [31:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("ok   %s: %h (cycle %0d)", name, act, cyc);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, then observe what the
  // DUT will do at the next rising edge and update the reference model.
  task automatic step(input logic g, input logic r, input logic rd,
                      input logic [31:0] tgt);
    int lat;
    int t;
    @(negedge clk);
    cyc++;
    if (pend.size() > 0 && pend[0].t <= cyc) begin
      if_rvalid_i = 1'b1;
      if_rdata_i  = mem(pend[0].adr);
      void'(pend.pop_front());
    end else begin
      if_rvalid_i = 1'b0;
      if_rdata_i  = $urandom;
    end
    if_gnt_i       = g;
    dec_ready_i    = r;
    redirect_v_i   = rd;
    redirect_adr_i = tgt;
    #1;
    last_req   = if_req_o;
    last_adr   = if_adr_o;
    last_v     = instr_v_o;
    last_instr = instr_o;
    last_gnt   = 1'b0;
    if (rd) begin
      check("req_low_on_redirect", if_req_o === 1'b0, {31'b0, if_req_o}, 32'h0);
      exp_q.delete();
      exp_fetch = tgt;
    end else if (if_req_o && g) begin
      check("fetch_adr", if_adr_o === exp_fetch, if_adr_o, exp_fetch);
      lat = $urandom_range(lat_hi, lat_lo);
      t   = cyc + lat;
      if (t <= last_t) t = last_t + 1;
      last_t = t;
      pend.push_back('{adr: if_adr_o, t: t});
      exp_q.push_back(if_adr_o);
      exp_fetch      = exp_fetch + 32'd4;
      last_gnt       = 1'b1;
      last_grant_adr = if_adr_o;
      grants++;
    end
  endtask

  // Monitor: every word decode accepts must be the next expected one.
  logic [31:0] mon_e;
  always @(negedge clk) begin
    #2;
    if (reset_n === 1'b1 && instr_v_o === 1'b1 && dec_ready_i === 1'b1 &&
        redirect_v_i === 1'b0) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL stale_instr: pc_o=%h instr_o=%h expected=none", pc_o, instr_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (pc_o !== mon_e || instr_o !== mem(mon_e)) begin
          bad++;
          $display("FAIL deliver: pc_o=%h instr_o=%h expected pc=%h instr=%h",
                   pc_o, instr_o, mon_e, mem(mon_e));
        end else begin
          $display("deliver pc=%h instr=%h", pc_o, instr_o);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n      = 1'b0;
    if_gnt_i     = 1'b0;
    if_rvalid_i  = 1'b0;
    redirect_v_i = 1'b0;
    dec_ready_i  = 1'b0;
    pend.delete();
    exp_q.delete();
    last_t = cyc;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_req",    if_req_o === 1'b0,  {31'b0, if_req_o},  32'h0);
    check("rst_valid",  instr_v_o === 1'b0, {31'b0, instr_v_o}, 32'h0);
    check("rst_instr",  instr_o === 32'h0,  instr_o, 32'h0);
    check("rst_pc",     pc_o === 32'h0,     pc_o,    32'h0);
    check("rst_adr",    if_adr_o === RST_ADR, if_adr_o, RST_ADR);
    reset_n   = 1'b1;
    exp_fetch = RST_ADR;
  endtask

  task automatic drain();
    repeat (15) step(1'b0, 1'b1, 1'b0, 32'h0);
    check("drain_empty", exp_q.size() == 0, exp_q.size(), 32'h0);
  endtask

  initial begin
    int c0;
    int seen;
    int g0;
    reset_n        = 1'b0;
    if_gnt_i       = 1'b0;
    if_rvalid_i    = 1'b0;
    if_rdata_i     = '0;
    redirect_v_i   = 1'b0;
    redirect_adr_i = '0;
    dec_ready_i    = 1'b0;
    exp_fetch      = RST_ADR;

    // Basic streaming and first-word latency
    do_reset();
    lat_lo = 1; lat_hi = 1;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("first_grant", last_gnt === 1'b1, {31'b0, last_gnt}, 32'h1);
    c0 = cyc;
    seen = -1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      if (last_v === 1'b1) begin
        seen = cyc;
        break;
      end
    end
`ifdef FETCH_BYPASS_EN
    check("latency", seen == c0 + 1, seen - c0, 32'd1);
`else
    check("latency", seen == c0 + 2, seen - c0, 32'd2);
`endif
    drain();

    // Backpressure: exactly DEPTH grants, then fetch resumes at 0x10
    do_reset();
    g0 = grants;
    repeat (10) step(1'b1, 1'b0, 1'b0, 32'h0);
    check("bp_grants", grants - g0 == 4, grants - g0, 32'd4);
    check("bp_req_low", last_req === 1'b0, {31'b0, last_req}, 32'h0);
    check("bp_full_valid", last_v === 1'b1, {31'b0, last_v}, 32'h1);
    g0 = grants;
    for (int i = 0; i < 5 && grants == g0; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("bp_resume_adr", grants != g0 && last_grant_adr === 32'h10,
          last_grant_adr, 32'h10);
    drain();

    // Stalled grant: address held at 0x8
    do_reset();
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      check("stall_adr", last_req === 1'b1 && last_adr === 32'h8, last_adr, 32'h8);
    end
    step(1'b1, 1'b1, 1'b0, 32'h0);
    drain();

    // Redirect with three requests in flight (latency 3)
    do_reset();
    lat_lo = 3; lat_hi = 3;
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h100);
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
    drain();

    // Redirect coinciding with a response and a pending pop
    do_reset();
    lat_lo = 1; lat_hi = 1;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h200);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check("redir_next_adr", last_req === 1'b1 && last_adr === 32'h200, last_adr, 32'h200);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    drain();

    // PC wrap
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("wrap_adr", last_gnt === 1'b1 && last_grant_adr === 32'h0, last_grant_adr, 32'h0);
    drain();

`ifdef FETCH_BYPASS_EN
    // Same-cycle bypass with an empty FIFO
    do_reset();
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check("bypass_instr", last_v === 1'b1 && last_instr === 32'h13, last_instr, 32'h13);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check("bypass_count0", last_v === 1'b0, {31'b0, last_v}, 32'h0);
`endif

    // Randomized traffic against the reference model
    do_reset();
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 10) < 7, ($urandom % 10) < 6, ($urandom % 40) == 0, $urandom);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
